inst_fetch: RTL and testbench
=============================

INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-low reset, named clk and rst.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous active-low reset; 0 = in reset.
REQ-004 inc_pc  input  1  controller request: advance to next sequential instruction.
REQ-005 branch  input  1  controller request: load branch_tgt into PC.
REQ-006 branch_tgt  input  8  branch destination address.
REQ-007 mem_req  output  1  instruction memory read request.
REQ-008 mem_addr  output  8  read address; always equals pc.
REQ-009 mem_ack  input  1  memory has valid mem_rdata this cycle.
REQ-010 mem_rdata  input  23  instruction word from memory.
REQ-011 code  output  23  instruction register; opcode in code[22:20].
REQ-012 start  output  1  one-cycle pulse: new instruction valid on code.
REQ-013 pc  output  8  current program counter.
REQ-014 halted  output  1  high once a HALT opcode (3'b111) has been fetched.
REQ-015 fetch_count  output  16  number of instructions issued, saturating.

Function
REQ-016 The FSM SHALL have states IDLE, FETCH, ISSUE, EXEC, HALT; all registered, no combinational path from inputs to start.
REQ-017 IDLE: mem_req=0; unconditionally -> FETCH on next edge.
REQ-018 FETCH: mem_req=1, mem_addr=pc; stay while mem_ack=0; on mem_ack=1 edge, code<=mem_rdata and -> ISSUE.
REQ-019 mem_addr SHALL remain stable for the entire time mem_req=1.
REQ-020 ISSUE: start=1 for exactly this one cycle; fetch_count<=fetch_count+1 unless 16'hFFFF; if code[22:20]==3'b111 -> HALT, else -> EXEC.
REQ-021 EXEC: start=0, mem_req=0; hold until controller responds.
REQ-022 EXEC with branch=1: pc<=branch_tgt, -> FETCH (branch takes priority over inc_pc when both high).
REQ-023 EXEC with inc_pc=1, branch=0: pc<=pc+1 modulo 256 (8'hFF wraps to 8'h00), -> FETCH.
REQ-024 inc_pc and branch SHALL be ignored in IDLE, FETCH, ISSUE, HALT; pc changes only in EXEC.
REQ-025 mem_ack SHALL be ignored outside FETCH; code changes only on FETCH acceptance.
REQ-026 HALT: halted=1, mem_req=0, start=0; state, pc, code held until reset.
REQ-027 Issue-to-next-start latency with zero-wait memory: controller response cycle + 1 (FETCH) + 1 (ISSUE), i.e. start pulses no more often than every 3 cycles.

Reset
REQ-028 While rst=0: state=IDLE, pc=8'h00, code=23'h0, start=0, mem_req=0, halted=0, fetch_count=0, regardless of clk.
REQ-029 Reset asserted mid-FETCH or mid-EXEC SHALL abort immediately; pending ack/branch/inc_pc is discarded.
REQ-030 After rst deasserts, first edge -> FETCH; mem_req=1 with mem_addr=0 from the second cycle.

Verification
REQ-031 Reset release, memory acks same cycle with 23'h012345 -> mem_addr=0, code=23'h012345, start pulses one cycle, fetch_count=1.
REQ-032 Two-cycle wait (mem_ack low 2 cycles) -> mem_req held high, mem_addr constant, no start until ack.
REQ-033 pc=8'hFF in EXEC, inc_pc=1 -> pc=8'h00, next mem_addr=8'h00.
REQ-034 EXEC, branch=1 and inc_pc=1 same cycle, branch_tgt=8'h40 -> pc=8'h40, not 8'h41.
REQ-035 Fetch word with code[22:20]=3'b111 -> start pulses once, halted=1, later inc_pc/branch/mem_ack produce no change.
REQ-036 rst pulled low during FETCH with mem_ack=1 -> all outputs at reset values asynchronously, code stays 0.

Source files
------------

// File: rtl/inst_fetch.sv
// -----------------------------------------------------------------------------
// inst_fetch
//
// Instruction fetch sequencer. Fetches one instruction word from memory at the
// current program counter, presents it on code with a one-cycle start pulse,
// then waits for the controller. The controller either branches or advances
// to the next sequential address, which starts the next fetch. A HALT opcode
// (3'b111 in code[22:20]) parks the unit until reset.
//
// Ports
//   clk          in   1   rising-edge clock
//   rst          in   1   asynchronous reset, active low (0 = in reset)
//   inc_pc       in   1   controller: advance to next sequential instruction
//   branch       in   1   controller: load branch_tgt into pc (wins over inc_pc)
//   branch_tgt   in   8   branch destination
//   mem_req      out  1   instruction memory read request
//   mem_addr     out  8   read address, always equal to pc
//   mem_ack      in   1   mem_rdata is valid this cycle
//   mem_rdata    in  23   instruction word from memory
//   code         out 23   instruction register, opcode in code[22:20]
//   start        out  1   one-cycle pulse: new instruction valid on code
//   pc           out  8   program counter
//   halted       out  1   a HALT opcode has been fetched
//   fetch_count  out 16   instructions issued, saturating at 16'hFFFF
// -----------------------------------------------------------------------------
module inst_fetch (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc_pc,
    input  logic        branch,
    input  logic [7:0]  branch_tgt,
    output logic        mem_req,
    output logic [7:0]  mem_addr,
    input  logic        mem_ack,
    input  logic [22:0] mem_rdata,
    output logic [22:0] code,
    output logic        start,
    output logic [7:0]  pc,
    output logic        halted,
    output logic [15:0] fetch_count
);

    localparam logic [2:0]  OP_HALT   = 3'b111;
    localparam logic [15:0] COUNT_MAX = 16'hFFFF;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_ISSUE = 3'd2,
        S_EXEC  = 3'd3,
        S_HALT  = 3'd4
    } state_t;

    state_t      state_reg, state_next;
    logic [7:0]  pc_reg, pc_next;
    logic [22:0] code_reg, code_next;
    logic [15:0] count_reg, count_next;

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= S_IDLE;
            pc_reg    <= 8'h00;
            code_reg  <= 23'h0;
            count_reg <= 16'h0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            code_reg  <= code_next;
            count_reg <= count_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and datapath update. Inputs are only looked at in the state
    // that owns them: mem_ack/mem_rdata in FETCH, branch/inc_pc in EXEC.
    // -------------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        code_next  = code_reg;
        count_next = count_reg;

        case (state_reg)
            S_IDLE: begin
                state_next = S_FETCH;
            end

            S_FETCH: begin
                // pc is frozen here, so mem_addr stays stable across waits
                if (mem_ack) begin
                    code_next  = mem_rdata;
                    state_next = S_ISSUE;
                end
            end

            S_ISSUE: begin
                if (count_reg != COUNT_MAX) begin
                    count_next = count_reg + 16'd1;
                end
                if (code_reg[22:20] == OP_HALT) begin
                    state_next = S_HALT;
                end else begin
                    state_next = S_EXEC;
                end
            end

            S_EXEC: begin
                if (branch) begin
                    pc_next    = branch_tgt;
                    state_next = S_FETCH;
                end else if (inc_pc) begin
                    // 8-bit add wraps 8'hFF to 8'h00
                    pc_next    = pc_reg + 8'd1;
                    state_next = S_FETCH;
                end
            end

            S_HALT: begin
                state_next = S_HALT;
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Outputs: decoded purely from registered state, so start and mem_req have
    // no combinational path from any input.
    // -------------------------------------------------------------------------
    always_comb begin
        mem_req = 1'b0;
        start   = 1'b0;
        halted  = 1'b0;

        case (state_reg)
            S_FETCH: mem_req = 1'b1;
            S_ISSUE: start   = 1'b1;
            S_HALT:  halted  = 1'b1;
            default: ;
        endcase
    end

    assign mem_addr    = pc_reg;
    assign pc          = pc_reg;
    assign code        = code_reg;
    assign fetch_count = count_reg;

endmodule

// File: tb/tb_inst_fetch.sv
module tb_inst_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        inc_pc = 1'b0;
    logic        branch = 1'b0;
    logic [7:0]  branch_tgt = 8'h00;
    logic        mem_ack = 1'b0;
    logic [22:0] mem_rdata = 23'h0;
    logic        mem_req;
    logic [7:0]  mem_addr;
    logic [22:0] code;
    logic        start;
    logic [7:0]  pc;
    logic        halted;
    logic [15:0] fetch_count;

    int n_tests = 0;
    int n_fail  = 0;

    inst_fetch dut (
        .clk         (clk),
        .rst         (rst),
        .inc_pc      (inc_pc),
        .branch      (branch),
        .branch_tgt  (branch_tgt),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .code        (code),
        .start       (start),
        .pc          (pc),
        .halted      (halted),
        .fetch_count (fetch_count)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Behavioural model: which phase of the fetch cycle we are in, plus the
    // architectural values pc / instruction register / issue count.
    // ------------------------------------------------------------------
    localparam int P_IDLE  = 0;
    localparam int P_FETCH = 1;
    localparam int P_ISSUE = 2;
    localparam int P_EXEC  = 3;
    localparam int P_HALT  = 4;

    int          m_phase;
    logic [7:0]  m_pc;
    logic [22:0] m_code;
    logic [15:0] m_count;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = P_IDLE;
        m_pc    = 8'h00;
        m_code  = 23'h0;
        m_count = 16'h0;
    endtask

    // One rising edge worth of behaviour, using inputs as seen at the edge.
    task automatic model_step();
        if (!rst) begin
            model_reset();
        end else begin
            case (m_phase)
                P_IDLE:  m_phase = P_FETCH;
                P_FETCH: if (mem_ack) begin
                    m_code  = mem_rdata;
                    m_phase = P_ISSUE;
                end
                P_ISSUE: begin
                    if (m_count < 16'hFFFF) m_count = m_count + 16'd1;
                    m_phase = (m_code[22:20] == 3'b111) ? P_HALT : P_EXEC;
                end
                P_EXEC: begin
                    if (branch) begin
                        m_pc    = branch_tgt;
                        m_phase = P_FETCH;
                    end else if (inc_pc) begin
                        m_pc    = 8'((int'(m_pc) + 1) % 256);
                        m_phase = P_FETCH;
                    end
                end
                default: ;
            endcase
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    // Called right after a falling edge: pull reset mid-cycle, check that the
    // outputs react without a clock, hold for some edges, then release.
    task automatic async_reset(input int hold);
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        chk("arst_mem_req", 32'(mem_req), 32'd0);
        chk("arst_start", 32'(start), 32'd0);
        chk("arst_halted", 32'(halted), 32'd0);
        chk("arst_pc", 32'(pc), 32'd0);
        chk("arst_mem_addr", 32'(mem_addr), 32'd0);
        chk("arst_code", 32'(code), 32'd0);
        chk("arst_count", 32'(fetch_count), 32'd0);
        repeat (hold) tick();
        chk("arst_hold_code", 32'(code), 32'd0);
        rst = 1'b1;
    endtask

    task automatic drive_random();
        inc_pc     = 1'($urandom_range(0, 1));
        branch     = ($urandom_range(0, 3) == 0);
        branch_tgt = 8'($urandom);
        mem_ack    = 1'($urandom_range(0, 1));
        mem_rdata  = 23'($urandom);
        if ($urandom_range(0, 29) != 0 && mem_rdata[22:20] == 3'b111)
            mem_rdata[22:20] = 3'($urandom_range(0, 6));
    endtask

    // ------------------------------------------------------------------
    // Per-cycle compare against the model plus protocol invariants
    // ------------------------------------------------------------------
    logic       prev_req = 1'b0;
    logic [7:0] prev_addr = 8'h00;
    int         since_start = 100;

    always @(negedge clk) begin
        chk("mem_req", 32'(mem_req), 32'(m_phase == P_FETCH));
        chk("start", 32'(start), 32'(m_phase == P_ISSUE));
        chk("halted", 32'(halted), 32'(m_phase == P_HALT));
        chk("pc", 32'(pc), 32'(m_pc));
        chk("mem_addr", 32'(mem_addr), 32'(m_pc));
        chk("code", 32'(code), 32'(m_code));
        chk("fetch_count", 32'(fetch_count), 32'(m_count));

        if (mem_req && prev_req)
            chk("addr_stable", 32'(mem_addr), 32'(prev_addr));
        prev_req  = mem_req;
        prev_addr = mem_addr;

        if (!rst) begin
            since_start = 100;
        end else begin
            if (since_start < 100) since_start++;
            if (start) begin
                n_tests++;
                if (since_start < 3) begin
                    n_fail++;
                    $display("FAIL start_spacing: got gap %0d expected >= 3 at %0t", since_start, $time);
                end
                since_start = 0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        int halt_cycles;
        model_reset();
        rst = 1'b0;
        repeat (3) tick();
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_pc", 32'(pc), 32'd0);
        chk("rst_count", 32'(fetch_count), 32'd0);

        // Reset release, zero-wait memory
        rst = 1'b1;
        mem_ack = 1'b1;
        mem_rdata = 23'h012345;
        tick();
        chk("first_req", 32'(mem_req), 32'd1);
        chk("first_addr", 32'(mem_addr), 32'd0);
        tick();
        chk("first_start", 32'(start), 32'd1);
        chk("first_code", 32'(code), 32'h012345);
        mem_ack = 1'b0;
        tick();
        chk("first_start_end", 32'(start), 32'd0);
        chk("first_count", 32'(fetch_count), 32'd1);

        // Sequential advance, then two wait cycles in FETCH
        inc_pc = 1'b1;
        tick();
        inc_pc = 1'b0;
        chk("wait_req0", 32'(mem_req), 32'd1);
        chk("wait_addr0", 32'(mem_addr), 32'd1);
        tick();
        chk("wait_req1", 32'(mem_req), 32'd1);
        chk("wait_addr1", 32'(mem_addr), 32'd1);
        chk("wait_nostart", 32'(start), 32'd0);
        mem_ack = 1'b1;
        mem_rdata = 23'h100000;
        tick();
        chk("wait_start", 32'(start), 32'd1);
        mem_ack = 1'b0;
        tick();
        chk("wait_count", 32'(fetch_count), 32'd2);

        // pc wrap from 8'hFF
        branch = 1'b1;
        branch_tgt = 8'hFF;
        tick();
        branch = 1'b0;
        chk("br_ff_pc", 32'(pc), 32'hFF);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        tick();
        inc_pc = 1'b1;
        tick();
        inc_pc = 1'b0;
        chk("wrap_pc", 32'(pc), 32'h00);
        chk("wrap_addr", 32'(mem_addr), 32'h00);

        // branch beats inc_pc
        mem_ack = 1'b1;
        mem_rdata = 23'h2ABCDE;
        tick();
        mem_ack = 1'b0;
        tick();
        branch = 1'b1;
        inc_pc = 1'b1;
        branch_tgt = 8'h40;
        tick();
        branch = 1'b0;
        inc_pc = 1'b0;
        chk("prio_pc", 32'(pc), 32'h40);
        chk("prio_addr", 32'(mem_addr), 32'h40);

        // Reset in FETCH with an ack pending
        mem_ack = 1'b1;
        mem_rdata = 23'h7ABCDE;
        async_reset(2);
        mem_ack = 1'b0;

        // HALT opcode
        mem_ack = 1'b1;
        mem_rdata = 23'h700001;
        tick();
        tick();
        chk("halt_start", 32'(start), 32'd1);
        chk("halt_code", 32'(code), 32'h700001);
        tick();
        chk("halt_flag", 32'(halted), 32'd1);
        chk("halt_count", 32'(fetch_count), 32'd1);
        for (int i = 0; i < 12; i++) begin
            drive_random();
            tick();
            chk("halt_hold_start", 32'(start), 32'd0);
            chk("halt_hold_pc", 32'(pc), 32'd0);
            chk("halt_hold_code", 32'(code), 32'h700001);
        end

        // Randomized run with occasional asynchronous resets
        async_reset(1);
        halt_cycles = 0;
        for (int i = 0; i < 4000; i++) begin
            drive_random();
            if ($urandom_range(0, 249) == 0 || halt_cycles > 15) begin
                async_reset($urandom_range(1, 2));
                halt_cycles = 0;
            end else begin
                tick();
                if (m_phase == P_HALT) halt_cycles++;
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
